// File: rtl/strl_pkg.sv
// Shared helpers for the strl_fifo elastic buffer: width helpers and
// parameter-legality checks evaluated at elaboration time.
package strl_pkg;

  // Pointer width for a DEPTH-entry store (never narrower than 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Width needed to hold an occupancy from 0 to DEPTH inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // DEPTH must be a power of two and at least 2 so pointers wrap naturally.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // The almost-full threshold must be reachable and non-trivial.
  function automatic bit af_ok(input int af, input int depth);
    return (af >= 1) && (af <= depth);
  endfunction

endpackage

// File: rtl/strl_fifo_mem.sv
// Payload storage for strl_fifo: DEPTH x DW register array, one synchronous
// write port and one asynchronous read port. Payload is never reset; the
// control logic guarantees stale entries are never presented.
module strl_fifo_mem
  import strl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/strl_fifo.sv
// strl_fifo: DEPTH-entry elastic buffer between a slave (s) stream and a
// master (m) stream, with fill level, almost-full flag and a wrapping count
// of master-side beats.
//
// Handshake: a beat moves on a side in every cycle where that side's valid
// and ready are both high (sflag / mflag). A source keeps valid and payload
// steady until the beat moves; ready_s is derived from registered state only,
// so it never depends on ready_m.
//
// Optional macro STRL_FIFO_BYPASS_EN: when the buffer is empty, the slave
// beat is presented combinationally on the master side; if it is taken the
// same cycle it is never written to storage.
module strl_fifo
  import strl_pkg::*;
#(
  parameter int DW     = 32,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = 3,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              data_s,
  input  logic                       vld_s,
  output logic                       ready_s,
  output logic [DW-1:0]              data_m,
  output logic                       vld_m,
  input  logic                       ready_m,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic [CNT_W-1:0]           beat_cnt
);

  localparam int AW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam bit DEPTH_LEGAL = depth_ok(DEPTH);
  localparam bit AF_LEGAL    = af_ok(AF_LVL, DEPTH);

  if (!DEPTH_LEGAL) begin : g_bad_depth
    $error("strl_fifo: DEPTH must be a power of two and >= 2");
  end
  if (!AF_LEGAL) begin : g_bad_af
    $error("strl_fifo: AF_LVL must be in 1..DEPTH");
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0] rdata;
  logic sflag, mflag, push, pop, bypass, not_empty;

  assign not_empty = (level_q != '0);
  assign ready_s   = !rst && (level_q != LW'(DEPTH));
  assign sflag     = vld_s && ready_s;
  assign mflag     = vld_m && ready_m;

`ifdef STRL_FIFO_BYPASS_EN
  // Empty buffer: the slave beat is offered directly; a beat taken in the
  // same cycle bypasses storage entirely.
  assign bypass = !not_empty && vld_s && ready_m && !rst;
  assign vld_m  = !rst && (not_empty || vld_s);
  assign data_m = rst ? '0 : (not_empty ? rdata : data_s);
`else
  assign bypass = 1'b0;
  assign vld_m  = !rst && not_empty;
  assign data_m = vld_m ? rdata : '0;
`endif

  // Storage is only touched for beats that actually pass through it.
  assign push = sflag && !bypass;
  assign pop  = mflag && !bypass;

  // Pointers, occupancy and beat counter; reset drops all stored beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LW'(1);
      end
      if (mflag) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level       = level_q;
  assign almost_full = (level_q >= LW'(AF_LVL));
  assign beat_cnt    = cnt_q;

  strl_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (data_s),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_strl_fifo.sv
// Self-checking bench for strl_fifo (DW=8, DEPTH=4, AF_LVL=3, CNT_W=16).
// Honours STRL_FIFO_BYPASS_EN the same way as the design.
module tb_strl_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AF_LVL = 3;
  localparam int CNT_W = 16;

`ifdef STRL_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]    data_s = '0;
  logic             vld_s = 1'b0;
  logic             ready_s;
  logic [DW-1:0]    data_m;
  logic             vld_m;
  logic             ready_m = 1'b0;
  logic [2:0]       level;
  logic             almost_full;
  logic [CNT_W-1:0] beat_cnt;

  strl_fifo #(
    .DW(DW), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .data_s(data_s), .vld_s(vld_s), .ready_s(ready_s),
    .data_m(data_m), .vld_m(vld_m), .ready_m(ready_m),
    .level(level), .almost_full(almost_full), .beat_cnt(beat_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    @(posedge clk); #1;
    vld_s = v; data_s = d; ready_m = r;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; vld_s = 1'b0; data_s = '0; ready_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int n_push = 0;
  int max_lvl = 0;
  int mlevel;
  bit m_ready, m_vld;

  // Model level is the number of beats the bench has seen accepted and not
  // yet delivered; all DUT outputs are compared against it every cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready_s", {31'b0, ready_s}, 32'd0);
      chk("rst_vld_m", {31'b0, vld_m}, 32'd0);
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      mlevel = exp_q.size();
      if (int'(level) > max_lvl) max_lvl = int'(level);
      m_ready = (mlevel != DEPTH);
      chk("sb_ready_s", {31'b0, ready_s}, {31'b0, m_ready});
      chk("sb_level", {29'b0, level}, mlevel);
      chk("sb_almost_full", {31'b0, almost_full}, {31'b0, (mlevel >= AF_LVL)});
      chk("sb_beat_cnt", {16'b0, beat_cnt}, {16'b0, exp_cnt});
      if (vld_s && m_ready) begin
        exp_q.push_back(data_s);
        n_push++;
      end
      m_vld = (mlevel != 0) || (BYP && vld_s);
      chk("sb_vld_m", {31'b0, vld_m}, {31'b0, m_vld});
      if (m_vld) begin
        chk("sb_data_m", {24'b0, data_m}, {24'b0, exp_q[0]});
        if (ready_m) begin
          void'(exp_q.pop_front());
          exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          vld_s;
    logic [DW-1:0] data_s;
    logic          ready_m;
    logic          e_ready_s;
    logic          e_vld_m;
    logic [DW-1:0] e_data_m;
    logic [2:0]    e_level;
    logic          e_af;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      drive(1'b0, '0, 1'b1);
      sample();
      cyc++;
    end
    if (exp_q.size() != 0) chk({name, "_drain_timeout"}, 32'd1, 32'd0);
    drive(1'b0, '0, 1'b0);
  endtask

  initial begin : main
    int cyc;
    int target;
    logic [DW-1:0] d;

    // fill with ready_m=0, then a fifth beat that must bounce, then drain
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, BYP, (BYP ? 8'h11 : 8'h00), 3'd0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1, 16'd0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1, 16'd0};
    tbl[5] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1, 16'd0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1, 16'd1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2, 1'b0, 16'd2};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1, 1'b0, 16'd3};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 16'd4};

    do_reset();
    sample();
    chk("reset_level", {29'b0, level}, 32'd0);
    chk("reset_vld_m", {31'b0, vld_m}, 32'd0);
    chk("reset_data_m", {24'b0, data_m}, 32'd0);
    chk("reset_beat_cnt", {16'b0, beat_cnt}, 32'd0);
    chk("reset_almost_full", {31'b0, almost_full}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].vld_s, tbl[i].data_s, tbl[i].ready_m);
      sample();
      chk($sformatf("tbl%0d_ready_s", i), {31'b0, ready_s}, {31'b0, tbl[i].e_ready_s});
      chk($sformatf("tbl%0d_vld_m", i), {31'b0, vld_m}, {31'b0, tbl[i].e_vld_m});
      if (tbl[i].e_vld_m || i == 0)
        chk($sformatf("tbl%0d_data_m", i), {24'b0, data_m}, {24'b0, tbl[i].e_data_m});
      chk($sformatf("tbl%0d_level", i), {29'b0, level}, {29'b0, tbl[i].e_level});
      chk($sformatf("tbl%0d_af", i), {31'b0, almost_full}, {31'b0, tbl[i].e_af});
      chk($sformatf("tbl%0d_beat_cnt", i), {16'b0, beat_cnt}, {16'b0, tbl[i].e_cnt});
    end

    // reset mid-operation at level 3
    drive(1'b1, 8'hA1, 1'b0);
    drive(1'b1, 8'hA2, 1'b0);
    drive(1'b1, 8'hA3, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    sample();
    chk("mid_level3", {29'b0, level}, 32'd3);
    @(posedge clk); #1 rst = 1'b1; ready_m = 1'b1;
    sample();
    chk("mid_rst_ready_s", {31'b0, ready_s}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    sample();
    chk("mid_after_level", {29'b0, level}, 32'd0);
    chk("mid_after_vld_m", {31'b0, vld_m}, 32'd0);
    chk("mid_after_beat_cnt", {16'b0, beat_cnt}, 32'd0);
    chk("mid_after_ready_s", {31'b0, ready_s}, 32'd1);
    drive(1'b0, '0, 1'b0);

    // 100 cycles of full-rate streaming
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      sample();
      if (i == 0) chk("stream_first_vld_m", {31'b0, vld_m}, {31'b0, BYP});
      if (i == 1 && !BYP) chk("stream_first_data", {24'b0, data_m}, 32'd0);
      chk("stream_level", {29'b0, level}, (BYP || i == 0) ? 32'd0 : 32'd1);
    end
    drive(1'b0, '0, 1'b0);
    sample();
    chk("stream_beat_cnt", {16'b0, beat_cnt}, BYP ? 32'd100 : 32'd99);
    drain("stream");

    // random backpressure, 10k accepted beats
    target = n_push + 10000;
    max_lvl = 0;
    cyc = 0;
    while (n_push < target && cyc < 40000) begin
      drive($urandom_range(0, 99) < 80, DW'($urandom_range(0, 255)), $urandom_range(0, 99) < 75);
      sample();
      cyc++;
    end
    chk("rand_completed", {31'b0, (n_push >= target)}, 32'd1);
    drain("rand");
    chk("rand_max_level_le_4", {31'b0, (max_lvl <= DEPTH)}, 32'd1);

    // counter wrap: 65535 beats, then one more
    do_reset();
    cyc = 0;
    d = '0;
    while (exp_cnt != 16'hFFFF && cyc < 70000) begin
      drive(1'b1, d, 1'b1);
      d = d + 1'b1;
      sample();
      cyc++;
    end
    chk("wrap_reached", {16'b0, exp_cnt}, 32'h0000FFFF);
    drive(1'b0, '0, 1'b0);
    sample();
    chk("wrap_cnt_ffff", {16'b0, beat_cnt}, 32'h0000FFFF);
    drive(exp_q.size() == 0, 8'h77, 1'b1);
    sample();
    drive(1'b0, '0, 1'b0);
    sample();
    chk("wrap_cnt_zero", {16'b0, beat_cnt}, 32'h00000000);
    drain("wrap");

`ifdef STRL_FIFO_BYPASS_EN
    // zero-latency cut-through at level 0
    drive(1'b1, 8'hA5, 1'b1);
    sample();
    chk("byp_vld_m", {31'b0, vld_m}, 32'd1);
    chk("byp_data_m", {24'b0, data_m}, 32'h000000A5);
    chk("byp_level_during", {29'b0, level}, 32'd0);
    drive(1'b0, '0, 1'b0);
    sample();
    chk("byp_level_after", {29'b0, level}, 32'd0);
`endif

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
